// File: rtl/ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// ex_stage_pipe
// Pipelined execute stage. Computes ALU, condition-set and branch results from
// decoded operands and holds them in an EX/MEM output register. Shifts and
// rotates run iteratively, one bit per cycle, in a small IDLE/SHIFT FSM.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             kill the in-flight shift and the held result
//   in_valid/in_ready upstream handshake (operands from ID/EX)
//   in_op/in_setop/in_br, in_a, in_b, in_imm, in_pc_plus_two  decoded inputs
//   out_valid/out_ready downstream handshake (EX/MEM register)
//   out_result, out_ofl, out_redirect, out_target  registered results
//   dbg_state         1 while the FSM is in SHIFT
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may depend combinationally on the consumer's ready.
// ---------------------------------------------------------------------------
module ex_stage_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_setop,
  input  logic [2:0]       in_br,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc_plus_two,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ofl,
  output logic             out_redirect,
  output logic [WIDTH-1:0] out_target,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]         sop_q, sop_d;   // in_op[1:0]: 0 ROL, 1 SLL, 2 ROR, 3 SRL
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_ofl_q, out_ofl_d;
  logic               out_redirect_q, out_redirect_d;
  logic [WIDTH-1:0]   out_target_q, out_target_d;

  logic               br_active, set_active, is_shift, accept, out_free;
  logic               taken, flag, one_ofl;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff, one_res, one_tgt, shifted;

  localparam int MSB = WIDTH - 1;

  assign br_active  = (in_br >= 3'd1) && (in_br <= 3'd6);
  assign set_active = in_setop[2];
  // Set and branch ops override in_op, so they never take the shift path.
  assign is_shift   = in_op[2] && !set_active && !br_active;
  assign amt        = in_b[SHAMT_W-1:0];
  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == IDLE) && out_free && !flush;
  assign accept     = in_valid && in_ready;

  // Single-cycle datapath for everything except multi-bit shifts.
  always_comb begin
    sum_ext = {1'b0, in_a} + {1'b0, in_b};
    diff    = in_a - in_b;

    flag = 1'b0;
    case (in_setop)
      3'd4:    flag = (in_a == in_b);
      3'd5:    flag = ($signed(in_a) <  $signed(in_b));
      3'd6:    flag = ($signed(in_a) <= $signed(in_b));
      3'd7:    flag = sum_ext[WIDTH];
      default: flag = 1'b0;
    endcase

    taken = 1'b0;
    case (in_br)
      3'd1:       taken = (in_a == '0);
      3'd2:       taken = (in_a != '0);
      3'd3:       taken = in_a[MSB];
      3'd4:       taken = !in_a[MSB];
      3'd5, 3'd6: taken = 1'b1;
      default:    taken = 1'b0;
    endcase

    one_ofl = 1'b0;
    one_res = in_a;  // shift with amount 0 passes A through
    if (br_active) begin
      one_res = in_pc_plus_two;  // link value
    end else if (set_active) begin
      one_res = {{(WIDTH-1){1'b0}}, flag};
    end else begin
      case (in_op)
        3'd0: begin
          one_res = sum_ext[WIDTH-1:0];
          one_ofl = (in_a[MSB] == in_b[MSB]) && (sum_ext[MSB] != in_a[MSB]);
        end
        3'd1: begin
          one_res = diff;
          one_ofl = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_a[MSB]);
        end
        3'd2:    one_res = in_a & in_b;
        3'd3:    one_res = in_a ^ in_b;
        default: one_res = in_a;
      endcase
    end

    one_tgt = in_pc_plus_two;
    if (taken) one_tgt = (in_br == 3'd6) ? (in_a + in_imm) : (in_pc_plus_two + in_imm);
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    shifted = work_q;
    case (sop_q)
      2'd0: shifted = {work_q[WIDTH-2:0], work_q[MSB]};
      2'd1: shifted = {work_q[WIDTH-2:0], 1'b0};
      2'd2: shifted = {work_q[0], work_q[MSB:1]};
      2'd3: shifted = {1'b0, work_q[MSB:1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    work_d         = work_q;
    pc_d           = pc_q;
    sop_d          = sop_q;
    out_valid_d    = out_valid_q && !out_ready;
    out_result_d   = out_result_q;
    out_ofl_d      = out_ofl_q;
    out_redirect_d = out_redirect_q;
    out_target_d   = out_target_q;

    if (flush) begin
      state_d        = IDLE;
      cnt_d          = '0;
      out_valid_d    = 1'b0;
      out_redirect_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (amt != '0)) begin
              state_d = SHIFT;
              cnt_d   = amt;
              work_d  = in_a;
              sop_d   = in_op[1:0];
              pc_d    = in_pc_plus_two;
            end else begin
              out_valid_d    = 1'b1;
              out_result_d   = one_res;
              out_ofl_d      = one_ofl;
              out_redirect_d = taken;
              out_target_d   = one_tgt;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            work_d = shifted;
            cnt_d  = cnt_q - 1'b1;
          end else if (out_free) begin
            // Count exhausted: park here until the output register frees up.
            state_d        = IDLE;
            out_valid_d    = 1'b1;
            out_result_d   = work_q;
            out_ofl_d      = 1'b0;
            out_redirect_d = 1'b0;
            out_target_d   = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      work_q         <= '0;
      pc_q           <= '0;
      sop_q          <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_ofl_q      <= 1'b0;
      out_redirect_q <= 1'b0;
      out_target_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      work_q         <= work_d;
      pc_q           <= pc_d;
      sop_q          <= sop_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_ofl_q      <= out_ofl_d;
      out_redirect_q <= out_redirect_d;
      out_target_q   <= out_target_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_ofl      = out_ofl_q;
  assign out_redirect = out_redirect_q;
  assign out_target   = out_target_q;
  assign dbg_state    = (state_q == SHIFT);

endmodule
